// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: pixel-format and cursor-mode constants plus the MSB-aligned
// bit-replication helper shared by the vga_fb_display blocks.
package vga_fb_pkg;
   localparam int PF_RGB111 = 0;
   localparam int PF_RGB332 = 1;
   localparam int PF_GREY8  = 2;
   typedef enum logic [1:0] {CUR_OFF, CUR_INV, CUR_WHITE, CUR_BLACK} cursor_mode_t;
   // value occupies value[in_width-1:0]; result occupies result[out_w-1:0]
   function automatic logic [15:0] expand_bits(input logic [7:0] value, input int in_width, input int out_w);
      logic [15:0] r;
      logic [2:0]  si;
      logic [3:0]  di;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         si = 3'(in_width - 1 - (i % in_width));
         di = 4'(out_w - 1 - i);
         if (i < out_w) r[di] = value[si];
      end
      return r;
   endfunction
endpackage

// File: rtl/vga_fb_display_delay.sv
// vga_fb_delay: WIDTH x DEPTH shift register, synchronously cleared, used to
// align sync/enable/cursor-hit with framebuffer read data.
module vga_fb_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_25mhz,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_sr [DEPTH];
   always_ff @(posedge clk_25mhz)
      if (reset) for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/vga_fb_display.sv
// vga_fb_display: framebuffer scan-out with pixel replication, format decode and
// blinking cursor overlay. Define VGA_FB_TEST_PATTERN_EN to add colour-bar test pattern.
module vga_fb_display
   import vga_fb_pkg::*;
#(
   parameter int FB_W        = 640,
   parameter int FB_H        = 480,
   parameter int ADDR_W      = 19,
   parameter int SCALE_SHIFT = 0,
   parameter int PIX_FMT     = 0,
   parameter int RAM_LAT     = 1,
   parameter int CURSOR_SIZE = 1,
   parameter int BLINK_DIV   = 12_500_000,
   parameter int OUT_W       = 4
) (
   input  logic              clk_25mhz,
   input  logic              reset,
   input  logic              display_enable,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [9:0]        cursor_x,
   input  logic [9:0]        cursor_y,
   input  logic [1:0]        cursor_mode,
   input  logic              blink_en,
`ifdef VGA_FB_TEST_PATTERN_EN
   input  logic              test_pattern,
`endif
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [7:0]        bram_data,
   output logic [OUT_W-1:0]  vga_r,
   output logic [OUT_W-1:0]  vga_g,
   output logic [OUT_W-1:0]  vga_b,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              de_out
);
   localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic [10:0] W11 = 11'(FB_W);
   localparam logic [10:0] H11 = 11'(FB_H);
   localparam logic [10:0] CS11 = 11'(CURSOR_SIZE);
`ifdef VGA_FB_TEST_PATTERN_EN
   localparam int DW = 11;
`else
   localparam int DW = 7;
`endif
   logic [9:0] w_fx, w_fy;
   logic w_in_fb, w_cx_hit, w_cy_hit;
   assign w_fx = hcount >> SCALE_SHIFT;
   assign w_fy = vcount >> SCALE_SHIFT;
   assign w_in_fb = display_enable && {1'b0, w_fx} < W11 && {1'b0, w_fy} < H11;
   // 11-bit compares so a cursor near the right/bottom edge clips instead of wrapping
   assign w_cx_hit = {1'b0, w_fx} >= {1'b0, cursor_x} && {1'b0, w_fx} < {1'b0, cursor_x} + CS11;
   assign w_cy_hit = {1'b0, w_fy} >= {1'b0, cursor_y} && {1'b0, w_fy} < {1'b0, cursor_y} + CS11;
   always_ff @(posedge clk_25mhz)
      if (reset) bram_addr <= '0;
      else bram_addr <= w_in_fb ? ADDR_W'(w_fy) * ADDR_W'(FB_W) + ADDR_W'(w_fx) : '0;
   logic [DW-1:0] w_dly_in, w_dly;
`ifdef VGA_FB_TEST_PATTERN_EN
   logic [2:0] w_bar;
   assign w_bar = 3'((32'(w_fx) * 32'd8) / 32'(FB_W));
   assign w_dly_in = {test_pattern, 3'd7 - w_bar, display_enable, w_in_fb, hsync_in, vsync_in,
                      w_in_fb && w_cx_hit && w_cy_hit, cursor_mode};
`else
   assign w_dly_in = {display_enable, w_in_fb, hsync_in, vsync_in,
                      w_in_fb && w_cx_hit && w_cy_hit, cursor_mode};
`endif
   vga_fb_delay #(.WIDTH(DW), .DEPTH(RAM_LAT + 1)) u_delay (
      .clk_25mhz(clk_25mhz),
      .reset(reset),
      .i_d(w_dly_in),
      .o_q(w_dly)
   );
   cursor_mode_t w_mode;
   logic w_de, w_fb, w_hs, w_vs, w_hit, w_use111;
   logic [2:0] w_v111;
   assign {w_de, w_fb, w_hs, w_vs, w_hit} = w_dly[6:2];
   assign w_mode = cursor_mode_t'(w_dly[1:0]);
`ifdef VGA_FB_TEST_PATTERN_EN
   assign w_use111 = PIX_FMT == PF_RGB111 || w_dly[10];
   assign w_v111 = w_dly[10] ? w_dly[9:7] : bram_data[2:0];
`else
   assign w_use111 = PIX_FMT == PF_RGB111;
   assign w_v111 = bram_data[2:0];
`endif
   logic [CW-1:0] r_blink_cnt;
   logic r_visible;
   always_ff @(posedge clk_25mhz)
      if (reset) begin
         r_blink_cnt <= '0;
         r_visible <= 1'b1;
      end else if (r_blink_cnt == CW'(BLINK_DIV - 1)) begin
         r_blink_cnt <= '0;
         r_visible <= ~r_visible;
      end else r_blink_cnt <= r_blink_cnt + 1'b1;
   logic [3*OUT_W-1:0] w_dec, w_pix;
   logic w_ov;
   always_comb begin
      w_dec = w_use111 ? {OUT_W'(expand_bits({7'b0, w_v111[2]}, 1, OUT_W)),
                          OUT_W'(expand_bits({7'b0, w_v111[1]}, 1, OUT_W)),
                          OUT_W'(expand_bits({7'b0, w_v111[0]}, 1, OUT_W))} :
              PIX_FMT == PF_RGB332 ? {OUT_W'(expand_bits({5'b0, bram_data[7:5]}, 3, OUT_W)),
                                      OUT_W'(expand_bits({5'b0, bram_data[4:2]}, 3, OUT_W)),
                                      OUT_W'(expand_bits({6'b0, bram_data[1:0]}, 2, OUT_W))} :
              {3{OUT_W'(expand_bits(bram_data, 8, OUT_W))}};
      w_ov = w_hit && w_mode != CUR_OFF && (r_visible || !blink_en);
      w_pix = !w_fb ? '0 :
              !w_ov ? w_dec :
              w_mode == CUR_INV ? ~w_dec :
              w_mode == CUR_WHITE ? '1 : '0;
   end
   always_ff @(posedge clk_25mhz)
      if (reset) begin
         {vga_r, vga_g, vga_b} <= '0;
         {hsync_out, vsync_out, de_out} <= '0;
      end else begin
         {vga_r, vga_g, vga_b} <= w_pix;
         {hsync_out, vsync_out, de_out} <= {w_hs, w_vs, w_de};
      end
endmodule

// File: tb/tb_vga_fb_display.sv
// tb_vga_fb_display: directed checks of latency, addressing, formats, cursor,
// blink and mid-line reset across three parameterisations.
module tb_vga_fb_display;
   logic clk = 1'b0;
   always #20 clk = ~clk;
   logic reset, de, hs, vs, blink_en;
   logic [9:0] h, v, cx, cy;
   logic [1:0] mode;
   logic [18:0] a0, a1, a2;
   logic [7:0] d0 = '0, d1 = '0, d2 = '0;
   logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
   logic hs0, vs0, de0, hs1, vs1, de1, hs2, vs2, de2;
   logic [7:0] mem0 [int];
   logic [7:0] mem1 [int];
   logic [7:0] mem2 [int];
   int n_checks = 0, n_errors = 0;
   always @(posedge clk) begin
      d0 <= mem0.exists(int'(a0)) ? mem0[int'(a0)] : 8'h00;
      d1 <= mem1.exists(int'(a1)) ? mem1[int'(a1)] : 8'h00;
      d2 <= mem2.exists(int'(a2)) ? mem2[int'(a2)] : 8'h00;
   end
   vga_fb_display #(.FB_W(640), .FB_H(480), .ADDR_W(19), .SCALE_SHIFT(0), .PIX_FMT(0), .RAM_LAT(1),
                    .CURSOR_SIZE(4), .BLINK_DIV(8), .OUT_W(4)) u0 (
      .clk_25mhz(clk), .reset(reset), .display_enable(de), .hcount(h), .vcount(v),
      .hsync_in(hs), .vsync_in(vs), .cursor_x(cx), .cursor_y(cy), .cursor_mode(mode),
      .blink_en(blink_en),
`ifdef VGA_FB_TEST_PATTERN_EN
      .test_pattern(1'b0),
`endif
      .bram_addr(a0), .bram_data(d0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
      .hsync_out(hs0), .vsync_out(vs0), .de_out(de0));
   vga_fb_display #(.FB_W(320), .FB_H(240), .ADDR_W(19), .SCALE_SHIFT(1), .PIX_FMT(1), .RAM_LAT(1),
                    .CURSOR_SIZE(1), .BLINK_DIV(8), .OUT_W(4)) u1 (
      .clk_25mhz(clk), .reset(reset), .display_enable(de), .hcount(h), .vcount(v),
      .hsync_in(hs), .vsync_in(vs), .cursor_x(cx), .cursor_y(cy), .cursor_mode(mode),
      .blink_en(blink_en),
`ifdef VGA_FB_TEST_PATTERN_EN
      .test_pattern(1'b0),
`endif
      .bram_addr(a1), .bram_data(d1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
      .hsync_out(hs1), .vsync_out(vs1), .de_out(de1));
   vga_fb_display #(.FB_W(640), .FB_H(480), .ADDR_W(19), .SCALE_SHIFT(0), .PIX_FMT(2), .RAM_LAT(1),
                    .CURSOR_SIZE(1), .BLINK_DIV(8), .OUT_W(4)) u2 (
      .clk_25mhz(clk), .reset(reset), .display_enable(de), .hcount(h), .vcount(v),
      .hsync_in(hs), .vsync_in(vs), .cursor_x(cx), .cursor_y(cy), .cursor_mode(mode),
      .blink_en(blink_en),
`ifdef VGA_FB_TEST_PATTERN_EN
      .test_pattern(1'b0),
`endif
      .bram_addr(a2), .bram_data(d2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
      .hsync_out(hs2), .vsync_out(vs2), .de_out(de2));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic show(input logic [9:0] hh, input logic [9:0] vv);
      h = hh; v = vv; de = 1'b1;
      repeat (3) tick();
   endtask
   int whites, greens, run, max_run;
   initial begin
      mem0[5*640+10] = 8'h04;
      mem0[200*640+50] = 8'h02;
      mem1[1283] = 8'hE3;
      mem2[2*640+20] = 8'hA5;
      reset = 1'b1; de = 1'b1; hs = 1'b1; vs = 1'b1; h = 10'd10; v = 10'd5;
      cx = '0; cy = '0; mode = 2'd0; blink_en = 1'b0;
      repeat (4) tick();
      chk("reset_rgb", {r0, g0, b0}, 12'h000);
      chk("reset_sync_de", {hs0, vs0, de0}, 3'b000);
      chk("reset_addr", a0, 19'd0);
      reset = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0; h = '0; v = '0;
      repeat (4) tick();
      h = 10'd10; v = 10'd5; de = 1'b1; hs = 1'b1; vs = 1'b1;
      tick();
      chk("lat_addr", a0, 19'd3210);
      chk("lat_de_c1", de0, 1'b0);
      h = '0; v = '0; de = 1'b0; hs = 1'b0; vs = 1'b0;
      tick();
      chk("lat_de_c2", {hs0, de0}, 2'b00);
      tick();
      chk("lat_rgb_c3", {r0, g0, b0}, 12'hF00);
      chk("lat_sync_de_c3", {hs0, vs0, de0}, 3'b111);
      tick();
      chk("lat_after_c4", {de0, r0}, 5'h00);
      h = 10'd7; v = 10'd9; de = 1'b1;
      tick();
      chk("x2_addr", a1, 19'd1283);
      tick(); tick();
      chk("rgb332_E3", {r1, g1, b1}, 12'hF0F);
      h = 10'd640;
      tick();
      chk("x2_border_addr", a1, 19'd0);
      tick(); tick();
      chk("x2_border_rgb", {r1, g1, b1}, 12'h000);
      chk("x2_border_de", de1, 1'b1);
      show(10'd20, 10'd2);
      chk("grey8_A5", {r2, g2, b2}, 12'hAAA);
      cx = 10'd636; cy = 10'd100; mode = 2'd1;
      show(10'd636, 10'd100);
      chk("cur_inv_tl", {r0, g0, b0}, 12'hFFF);
      show(10'd639, 10'd103);
      chk("cur_inv_br", {r0, g0, b0}, 12'hFFF);
      show(10'd635, 10'd100);
      chk("cur_left_out", {r0, g0, b0}, 12'h000);
      show(10'd636, 10'd104);
      chk("cur_below_out", {r0, g0, b0}, 12'h000);
      show(10'd0, 10'd100);
      chk("cur_no_wrap", {r0, g0, b0}, 12'h000);
      cx = 10'd9; cy = 10'd4; mode = 2'd3;
      show(10'd10, 10'd5);
      chk("cur_black", {r0, g0, b0}, 12'h000);
      cx = 10'd50; cy = 10'd200; mode = 2'd2;
      show(10'd50, 10'd200);
      chk("cur_white_steady", {r0, g0, b0}, 12'hFFF);
      mode = 2'd0;
      show(10'd50, 10'd200);
      chk("cur_off_green", {r0, g0, b0}, 12'h0F0);
      mode = 2'd2; blink_en = 1'b1;
      repeat (3) tick();
      whites = 0; greens = 0; run = 0; max_run = 0;
      for (int i = 0; i < 32; i++) begin
         if ({r0, g0, b0} == 12'hFFF) begin whites++; run++; end
         else begin
            if ({r0, g0, b0} == 12'h0F0) greens++;
            run = 0;
         end
         if (run > max_run) max_run = run;
         tick();
      end
      chk("blink_whites", whites, 16);
      chk("blink_greens", greens, 16);
      chk("blink_max_run", max_run, 8);
      blink_en = 1'b0; mode = 2'd0;
      show(10'd10, 10'd5);
      chk("pre_reset_rgb", {r0, g0, b0}, 12'hF00);
      reset = 1'b1;
      tick();
      chk("rst_mid_rgb", {r0, g0, b0, de0}, 13'h0);
      chk("rst_mid_addr", a0, 19'd0);
      reset = 1'b0;
      tick();
      chk("rst_post1", {r0, g0, b0, de0}, 13'h0);
      tick();
      chk("rst_post2", {r0, g0, b0, de0}, 13'h0);
      tick();
      chk("rst_resume_rgb", {r0, g0, b0}, 12'hF00);
      chk("rst_resume_de", de0, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
